// File: rtl/data_mem_lsu.sv
// Byte/halfword load-store unit in front of a word-only data RAM.
// Optional misalignment trapping: define LSU_MISALIGN_TRAP_EN.
module data_mem_lsu #(
    parameter logic [31:0] ADDR_LIMIT = 32'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wData,
    input  logic [31:0] ram_rData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        rerr_q;

    logic        f3_bad;
    logic        mis;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] wr_word;

    always_comb begin
        f3_bad = 1'b0;
        if (req_we) begin
            f3_bad = (req_funct3 > 3'd2);
        end else begin
            f3_bad = !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = ((req_funct3[1:0] == 2'd1) && req_addr[0])
           || ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
`endif
        req_err = f3_bad || (req_addr >= ADDR_LIMIT) || mis;
    end

    // Without trapping, halfword lane comes from addr[1] only.
    always_comb begin
        byte_sel = ram_rData[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? ram_rData[31:16] : ram_rData[15:0];
        load_val = 32'd0;
        case (f3_q)
            3'd0:    load_val = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    load_val = {{16{half_sel[15]}}, half_sel};
            3'd2:    load_val = ram_rData;
            3'd4:    load_val = {24'd0, byte_sel};
            3'd5:    load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        wr_word = old_q;
        case (f3_q[1:0])
            2'd0:    wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'd1:    wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wr_word = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            old_q   <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        state_q <= READ;
                    end
                end
                READ: begin
                    old_q <= ram_rData;
                    if (err_q) begin
                        rdata_q <= 32'd0;
                        rerr_q  <= 1'b1;
                        state_q <= RESP;
                    end else if (!we_q) begin
                        rdata_q <= load_val;
                        rerr_q  <= 1'b0;
                        state_q <= RESP;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    rdata_q <= 32'd0;
                    rerr_q  <= 1'b0;
                    state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;
    assign ram_we     = (state_q == WRITE) && !reset;
    assign ram_addr   = {addr_q[31:2], 2'b00};
    assign ram_wData  = (state_q == WRITE) ? wr_word : wdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomised bench for data_mem_lsu against a byte-level reference model.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wData;
    logic [31:0] ram_rData;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rd_q [$];
    logic        exp_er_q [$];

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;

    data_mem_lsu #(.ADDR_LIMIT(32'h400)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wData(ram_wData),
        .ram_rData(ram_rData)
    );

    always #5 clk = ~clk;

    assign ram_rData = mem[ram_addr[9:2]];
    always @(posedge clk) if (ram_we) mem[ram_addr[9:2]] <= ram_wData;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: what a byte-addressed memory would do for this request.
    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic err, output logic [31:0] rd);
        logic [31:0] w, mask;
        logic [7:0]  b;
        logic [15:0] h;
        int          bsh, hsh;
        bool_chk: begin end
        if (we) err = (f3 > 2);
        else    err = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (addr >= 32'h400) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) err = 1'b1;
        if (f3 == 2 && (addr % 4 != 0)) err = 1'b1;
`endif
        rd = 32'd0;
        if (err) return;
        w   = ref_mem[addr[9:2]];
        bsh = 8 * (addr % 4);
        hsh = 16 * ((addr / 2) % 2);
        b   = 8'((w >> bsh) & 32'hFF);
        h   = 16'((w >> hsh) & 32'hFFFF);
        if (!we) begin
            case (f3)
                0: rd = {{24{b[7]}}, b};
                1: rd = {{16{h[15]}}, h};
                2: rd = w;
                4: rd = {24'd0, b};
                default: rd = {16'd0, h};
            endcase
        end else begin
            case (f3)
                0: begin
                    mask = 32'hFF << bsh;
                    w = (w & ~mask) | ((wd & 32'hFF) << bsh);
                end
                1: begin
                    mask = 32'hFFFF << hsh;
                    w = (w & ~mask) | ((wd & 32'hFFFF) << hsh);
                end
                default: w = wd;
            endcase
            ref_mem[addr[9:2]] = w;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ram_we) we_cnt++;
            if (resp_valid) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected 0");
                end else begin
                    check("resp_rdata", resp_rdata, exp_rd_q.pop_front());
                    check("resp_err", {31'd0, resp_err},
                          {31'd0, exp_er_q.pop_front()});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge of the response cycle.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] got_rd, output logic got_err);
        logic        e;
        logic [31:0] r;
        int          we0, n, g;
        model(we, f3, addr, wd, e, r);
        exp_rd_q.push_back(r);
        exp_er_q.push_back(e);
        we0 = we_cnt;
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        g = 0;
        while (!req_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_we = $urandom; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 8);
        check("latency", n, (e || !we) ? 3'd2 : 3'd3);
        check("ram_we_cycles", we_cnt - we0, (we && !e) ? 1 : 0);
        check("ram_word", mem[addr[9:2]], ref_mem[addr[9:2]]);
        got_rd  = resp_rdata;
        got_err = resp_err;
    endtask

    initial begin
        logic [31:0] rd, w;
        logic        er;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] ad;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            mem[i] = w;
            ref_mem[i] = w;
        end
        mem[0] = 32'h8899AABB;
        ref_mem[0] = 32'h8899AABB;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_we", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req(1'b0, 3'd0, 32'd1, 32'd0, rd, er);
        check("lb_lit", rd, 32'hFFFFFFAA);
        do_req(1'b0, 3'd4, 32'd1, 32'd0, rd, er);
        check("lbu_lit", rd, 32'h000000AA);
        do_req(1'b1, 3'd0, 32'd2, 32'h000000CC, rd, er);
        check("sb_lit", mem[0], 32'h88CCAABB);
        check("sb_err", {31'd0, er}, 32'd0);
        do_req(1'b1, 3'd1, 32'd6, 32'h00001234, rd, er);
        do_req(1'b0, 3'd1, 32'd6, 32'd0, rd, er);
        check("sh_lh_lit", rd, 32'h00001234);
        do_req(1'b0, 3'd2, 32'h400, 32'd0, rd, er);
        check("lw_oor_err", {31'd0, er}, 32'd1);
        check("lw_oor_rd", rd, 32'd0);
        do_req(1'b1, 3'd2, 32'd3, 32'hDEADBEEF, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        check("sw_mis_err", {31'd0, er}, 32'd1);
        check("sw_mis_mem", mem[0], 32'h88CCAABB);
`else
        check("sw_mis_err", {31'd0, er}, 32'd0);
        check("sw_mis_mem", mem[0], 32'hDEADBEEF);
`endif

        // Reset during the WRITE cycle of an SB to word 1.
        w = mem[1];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'd5; req_wdata = 32'h0000005A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_write_we", {31'd0, ram_we}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_write_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("rst_write_novalid", {31'd0, resp_valid}, 32'd0);
        end
        check("rst_write_mem", mem[1], w);

        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom);
            if ($urandom % 4 == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom % 5)
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            if ($urandom % 12 == 0) ad = 32'h400 + $urandom_range(0, 64);
            else if ($urandom % 30 == 0) ad = 32'hFFFFFFFC;
            else ad = $urandom_range(0, 31);
            do_req(we, f3, ad, $urandom, rd, er);
        end
        repeat (2) @(negedge clk);
        check("queue_drained", exp_rd_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
